// File: rtl/pos_reg_arbiter.sv
// Two-requester round-robin read port onto the position/status register map.
// Each grant serves one byte; an address-0 read also snapshots Y so X/Y pairs stay coherent.
module pos_reg_arbiter #(
    parameter logic [7:0] STATUS_VAL = 8'hC9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x_pos,
    input  logic [7:0] y_pos,
    input  logic       req0_valid,
    input  logic [1:0] req0_addr,
    input  logic       req1_valid,
    input  logic [1:0] req1_addr,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    // Handshake: a requester raises reqN_valid with a stable reqN_addr and holds
    // both until ackN pulses for one cycle; rdata is valid only in that cycle.
    // Valid must be low by the second edge after the ack cycle, else it is a new request.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       r_owner;
    logic [1:0] r_addr;
    logic       r_ack0;
    logic       r_ack1;
    logic [7:0] r_rdata;
    logic [7:0] r_shadow_y [2];
    logic [7:0] r_txn_cnt;
    logic       r_last_grant;

    logic       w_any_req;
    logic       w_grant;
    logic [1:0] w_grant_addr;
    logic [7:0] w_read_data;

    // On contention, the requester that did not win last time is granted.
    always_comb begin
        w_any_req    = req0_valid | req1_valid;
        w_grant      = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
        w_grant_addr = w_grant ? req1_addr : req0_addr;
    end

    always_comb begin
        w_read_data = r_txn_cnt;
        case (r_addr)
            2'd0:    w_read_data = x_pos;
            2'd1:    w_read_data = r_shadow_y[r_owner];
            2'd2:    w_read_data = STATUS_VAL;
            default: w_read_data = r_txn_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_SERVE;
            ST_SERVE: w_next_state = ST_ACK;
            ST_ACK:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner       <= 1'b0;
            r_addr        <= 2'd0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata       <= 8'h00;
            r_shadow_y[0] <= 8'h00;
            r_shadow_y[1] <= 8'h00;
            r_txn_cnt     <= 8'h00;
            r_last_grant  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_addr  <= w_grant_addr;
                    end
                end
                ST_SERVE: begin
                    r_rdata <= w_read_data;
                    r_ack0  <= ~r_owner;
                    r_ack1  <= r_owner;
                    if (r_addr == 2'd0) begin
                        r_shadow_y[r_owner] <= y_pos;
                    end
                end
                ST_ACK: begin
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_txn_cnt    <= r_txn_cnt + 8'd1;
                    r_last_grant <= r_owner;
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata       = r_rdata;
    assign busy        = (r_state == ST_SERVE) || (r_state == ST_ACK);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pos_reg_arbiter.sv
// Bench for pos_reg_arbiter: directed scenarios with literal expectations plus
// random two-requester traffic checked each cycle against a transaction-level model.
module tb_pos_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic       req0_valid;
    logic [1:0] req0_addr;
    logic       req1_valid;
    logic [1:0] req1_addr;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;
    logic [1:0] o_dbg_state;

    int errors = 0;
    int checks = 0;
    int grant_q[$];
    bit stop_xy;

    always #5 clk = ~clk;

    pos_reg_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata      (rdata),
        .busy       (busy),
        .o_dbg_state(o_dbg_state)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction takes three cycles after the request is
    // seen; the ack and data appear after the second edge, stats update after the third.
    initial begin : model
        int         phase;
        bit         owner;
        bit         last;
        logic [1:0] addr;
        logic [7:0] sh [2];
        logic [7:0] cnt;
        logic       e_ack0;
        logic       e_ack1;
        logic [7:0] e_rd;
        phase = 0; owner = 0; last = 1; addr = 0; cnt = 0;
        sh[0] = 0; sh[1] = 0; e_ack0 = 0; e_ack1 = 0; e_rd = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                phase = 0; last = 1; cnt = 0; sh[0] = 0; sh[1] = 0;
                e_ack0 = 0; e_ack1 = 0; e_rd = 0;
            end else if (phase == 0) begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) owner = !last;
                    else owner = req1_valid;
                    addr  = owner ? req1_addr : req0_addr;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (addr == 2'd0) begin
                    e_rd = x_pos;
                    sh[owner] = y_pos;
                end else if (addr == 2'd1) e_rd = sh[owner];
                else if (addr == 2'd2) e_rd = 8'hC9;
                else e_rd = cnt;
                e_ack0 = !owner;
                e_ack1 = owner;
                phase  = 2;
            end else begin
                e_ack0 = 0; e_ack1 = 0;
                cnt    = cnt + 8'd1;
                last   = owner;
                phase  = 0;
            end
            #1;
            check8("model_ack0", {7'b0, ack0}, {7'b0, e_ack0});
            check8("model_ack1", {7'b0, ack1}, {7'b0, e_ack1});
            check8("model_rdata", rdata, e_rd);
            check8("model_busy", {7'b0, busy}, {7'b0, phase != 0});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check8("reset_ack0", {7'b0, ack0}, 8'h00);
        check8("reset_ack1", {7'b0, ack1}, 8'h00);
        check8("reset_rdata", rdata, 8'h00);
        check8("reset_busy", {7'b0, busy}, 8'h00);
        rst = 0;
    endtask

    // Issues one read for a requester and returns the acked data.
    task automatic rd(input int who, input logic [1:0] a, output logic [7:0] d);
        bit got;
        got = 0;
        d = 8'hxx;
        @(negedge clk);
        if (who == 0) begin req0_valid = 1; req0_addr = a; end
        else begin req1_valid = 1; req1_addr = a; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((who == 0) ? ack0 : ack1) begin
                got = 1;
                d = rdata;
            end
        end
        if (who == 0) req0_valid = 0; else req1_valid = 0;
        check8("rd_handshake", {7'b0, got}, 8'h01);
    endtask

    task automatic agent(input int who, input int n, input bit rnd);
        bit got;
        for (int k = 0; k < n; k++) begin
            if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
            if (who == 0) begin
                req0_valid = 1;
                req0_addr  = rnd ? 2'($urandom_range(0, 3)) : 2'd2;
            end else begin
                req1_valid = 1;
                req1_addr  = rnd ? 2'($urandom_range(0, 3)) : 2'd2;
            end
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if ((who == 0) ? ack0 : ack1) got = 1;
            end
            check8("agent_handshake", {7'b0, got}, 8'h01);
            grant_q.push_back(who);
            if (who == 0) req0_valid = 0; else req1_valid = 0;
            @(negedge clk);
        end
    endtask

    initial begin : main
        logic [7:0] d;
        int exp_g;
        rst = 1; x_pos = 0; y_pos = 0;
        req0_valid = 0; req0_addr = 0; req1_valid = 0; req1_addr = 0;
        do_reset();

        // Latency of a single status read
        @(negedge clk);
        req0_valid = 1; req0_addr = 2'd2;
        @(negedge clk);
        check8("lat_e0_ack0", {7'b0, ack0}, 8'h00);
        check8("lat_e0_busy", {7'b0, busy}, 8'h01);
        @(negedge clk);
        check8("lat_e1_ack0", {7'b0, ack0}, 8'h01);
        check8("lat_e1_ack1", {7'b0, ack1}, 8'h00);
        check8("lat_e1_rdata", rdata, 8'hC9);
        req0_valid = 0;
        @(negedge clk);
        check8("lat_e2_ack0", {7'b0, ack0}, 8'h00);
        rd(0, 2'd3, d); check8("cnt_after_one", d, 8'h01);

        // Coherent pair
        x_pos = 8'h12; y_pos = 8'h34;
        rd(0, 2'd0, d); check8("pair_x", d, 8'h12);
        y_pos = 8'h99;
        rd(0, 2'd1, d); check8("pair_y", d, 8'h34);

        // Shadow isolation
        y_pos = 8'h34;
        rd(0, 2'd0, d); check8("iso_r0_x", d, 8'h12);
        y_pos = 8'h56;
        rd(1, 2'd0, d); check8("iso_r1_x", d, 8'h12);
        rd(1, 2'd1, d); check8("iso_r1_y", d, 8'h56);
        rd(0, 2'd1, d); check8("iso_r0_y", d, 8'h34);

        // Contention with both held: strict alternation starting with 0
        do_reset();
        grant_q.delete();
        fork
            agent(0, 4, 0);
            agent(1, 4, 0);
        join
        check8("contention_len", 8'(grant_q.size()), 8'd8);
        for (int i = 0; i < grant_q.size(); i++) begin
            exp_g = i % 2;
            check8("contention_order", 8'(grant_q[i]), 8'(exp_g));
        end

        // Counter wrap
        do_reset();
        repeat (256) rd(0, 2'd2, d);
        rd(1, 2'd3, d); check8("wrap_256", d, 8'h00);
        do_reset();
        repeat (255) rd(1, 2'd2, d);
        rd(0, 2'd3, d); check8("wrap_pre", d, 8'hFF);
        rd(0, 2'd3, d); check8("wrap_post", d, 8'h00);

        // Reset during SERVE
        do_reset();
        x_pos = 8'h12; y_pos = 8'h34;
        @(negedge clk);
        req0_valid = 1; req0_addr = 2'd0;
        @(negedge clk);
        check8("abort_serve_busy", {7'b0, busy}, 8'h01);
        rst = 1; req0_valid = 0;
        @(negedge clk);
        check8("abort_serve_ack0", {7'b0, ack0}, 8'h00);
        check8("abort_serve_busy0", {7'b0, busy}, 8'h00);
        rst = 0;
        rd(0, 2'd3, d); check8("abort_cnt", d, 8'h00);
        rd(0, 2'd1, d); check8("abort_sh0", d, 8'h00);
        rd(1, 2'd1, d); check8("abort_sh1", d, 8'h00);

        // Reset during ACK drops the pending ack
        @(negedge clk);
        req1_valid = 1; req1_addr = 2'd2;
        @(negedge clk);
        @(negedge clk);
        check8("abort_ack_high", {7'b0, ack1}, 8'h01);
        rst = 1; req1_valid = 0;
        @(negedge clk);
        check8("abort_ack_drop", {7'b0, ack1}, 8'h00);
        rst = 0;
        rd(1, 2'd3, d); check8("abort_ack_cnt", d, 8'h00);

        // Random traffic with moving coordinates
        stop_xy = 0;
        fork
            begin
                fork
                    agent(0, 60, 1);
                    agent(1, 60, 1);
                join
                stop_xy = 1;
            end
            begin
                while (!stop_xy) begin
                    @(negedge clk);
                    x_pos = 8'($urandom);
                    y_pos = 8'($urandom);
                end
            end
        join
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
